// File: rtl/instr_issue.sv
// -----------------------------------------------------------------------------
// instr_issue : instruction fetch / issue unit
//
// Holds the fetch PC, reads a synchronous instruction memory (1-cycle read
// latency) and buffers the responses in a 2-entry queue (head + skid). The
// head drives the downstream valid/ready interface directly. Execute can
// redirect the fetch stream, and any undefined opcode (opcode[3]=1) halts the
// unit until reset.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   imem_en/addr      read strobe and address toward instruction memory
//   imem_rdata        read data, valid the cycle after imem_en
//   instr_valid/ready downstream handshake; fire = valid & ready
//   instr/opcode      issued word and its top nibble
//   instr_pc          address of the issued word
//   redirect_valid/pc branch/jump redirect from execute
//   halted/illegal    fetch stopped / stopped because of an undefined opcode
// -----------------------------------------------------------------------------
module instr_issue #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_en,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         opcode,
   output logic [PC_W-1:0]    instr_pc,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               halted,
   output logic               illegal
);

   typedef enum logic {S_RUN, S_HALT} state_e;

   state_e               state_q, state_d;
   logic [PC_W-1:0]      fetch_pc_q, fetch_pc_d;
   logic                 pend_q, pend_d;
   logic [PC_W-1:0]      pend_pc_q, pend_pc_d;
   logic                 hd_vld_q, hd_vld_d;
   logic [INSTR_W-1:0]   hd_instr_q, hd_instr_d;
   logic [PC_W-1:0]      hd_pc_q, hd_pc_d;
   logic                 sk_vld_q, sk_vld_d;
   logic [INSTR_W-1:0]   sk_instr_q, sk_instr_d;
   logic [PC_W-1:0]      sk_pc_q, sk_pc_d;
   logic                 ill_q, ill_d;

   logic                 fire;
   logic [1:0]           occ;
   logic                 ld_vld;
   logic                 rd_to_hd;
   logic [INSTR_W-1:0]   ld_instr;
   logic [PC_W-1:0]      ld_pc;

   assign fire = hd_vld_q & instr_ready;
   // Slots committed after this cycle: head that stays, skid, in-flight read.
   assign occ  = {1'b0, hd_vld_q & ~fire} + {1'b0, sk_vld_q} + {1'b0, pend_q};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_d     = pend_q;
      pend_pc_d  = pend_pc_q;
      hd_vld_d   = hd_vld_q;
      hd_instr_d = hd_instr_q;
      hd_pc_d    = hd_pc_q;
      sk_vld_d   = sk_vld_q;
      sk_instr_d = sk_instr_q;
      sk_pc_d    = sk_pc_q;
      ill_d      = ill_q;
      imem_en    = 1'b0;
      ld_vld     = 1'b0;
      rd_to_hd   = 1'b0;
      ld_instr   = '0;
      ld_pc      = '0;

      if (state_q == S_RUN) begin
         if (redirect_valid) begin
            // Flush everything, including the read that returns next cycle.
            hd_vld_d   = 1'b0;
            sk_vld_d   = 1'b0;
            pend_d     = 1'b0;
            fetch_pc_d = redirect_pc;
         end else begin
            // Gated by rst_n so the strobe is quiet while reset is held.
            imem_en   = rst_n & (occ <= 2'd1);
            pend_d    = imem_en;
            pend_pc_d = fetch_pc_q;
            if (imem_en)
               fetch_pc_d = fetch_pc_q + {{(PC_W-1){1'b0}}, 1'b1};

            if (fire)
               hd_vld_d = 1'b0;

            // Head refills from skid first (older), else from the read data.
            if (!hd_vld_q || fire) begin
               if (sk_vld_q) begin
                  ld_vld   = 1'b1;
                  ld_instr = sk_instr_q;
                  ld_pc    = sk_pc_q;
                  sk_vld_d = 1'b0;
               end else if (pend_q) begin
                  ld_vld   = 1'b1;
                  rd_to_hd = 1'b1;
                  ld_instr = imem_rdata;
                  ld_pc    = pend_pc_q;
               end
            end

            if (pend_q && !rd_to_hd) begin
               sk_vld_d   = 1'b1;
               sk_instr_d = imem_rdata;
               sk_pc_d    = pend_pc_q;
            end

            if (ld_vld) begin
               if (ld_instr[INSTR_W-1]) begin
                  // Undefined opcode never reaches the head; drop all and stop.
                  state_d  = S_HALT;
                  ill_d    = 1'b1;
                  hd_vld_d = 1'b0;
                  sk_vld_d = 1'b0;
                  pend_d   = 1'b0;
               end else begin
                  hd_vld_d   = 1'b1;
                  hd_instr_d = ld_instr;
                  hd_pc_d    = ld_pc;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_RUN;
         fetch_pc_q <= '0;
         pend_q     <= 1'b0;
         pend_pc_q  <= '0;
         hd_vld_q   <= 1'b0;
         hd_instr_q <= '0;
         hd_pc_q    <= '0;
         sk_vld_q   <= 1'b0;
         sk_instr_q <= '0;
         sk_pc_q    <= '0;
         ill_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
         hd_vld_q   <= hd_vld_d;
         hd_instr_q <= hd_instr_d;
         hd_pc_q    <= hd_pc_d;
         sk_vld_q   <= sk_vld_d;
         sk_instr_q <= sk_instr_d;
         sk_pc_q    <= sk_pc_d;
         ill_q      <= ill_d;
      end
   end

   assign imem_addr   = fetch_pc_q;
   assign instr_valid = hd_vld_q;
   assign instr       = hd_instr_q;
   assign opcode      = hd_instr_q[INSTR_W-1 -: 4];
   assign instr_pc    = hd_pc_q;
   assign halted      = (state_q == S_HALT);
   assign illegal     = ill_q;

endmodule

// File: tb/tb_instr_issue.sv
// -----------------------------------------------------------------------------
// tb_instr_issue : directed bench for instr_issue with a scoreboard.
// The stimulus process pushes the expected issue order (pc, word) into queues;
// a monitor pops and compares on every downstream transfer.
// Memory model: mem[k] = {4'h0, k[11:0]} unless a test overrides a word.
// -----------------------------------------------------------------------------
module tb_instr_issue;

   logic        clk;
   logic        rst_n;
   logic        imem_en;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [7:0]  instr_pc;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        halted;
   logic        illegal;

   logic [15:0] mem [256];
   logic [7:0]  exp_pc_q [$];
   logic [15:0] exp_w_q  [$];
   int          total;
   int          bad;

   instr_issue #(.PC_W(8), .INSTR_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .opcode         (opcode),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .illegal        (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory, exactly one cycle of read latency.
   always @(posedge clk)
      if (imem_en === 1'b1) imem_rdata <= mem[imem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [7:0] pc);
      exp_pc_q.push_back(pc);
      exp_w_q.push_back({8'h00, pc});
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Two reset edges; outputs checked after the first. Returns in cycle 0.
   task automatic do_reset;
      rst_n = 1'b0;
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
      chk("rst_imem_en", {31'd0, imem_en},     32'd0);
      chk("rst_addr",    {24'd0, imem_addr},   32'd0);
      chk("rst_instr",   {16'd0, instr},       32'd0);
      chk("rst_pc",      {24'd0, instr_pc},    32'd0);
      chk("rst_halted",  {31'd0, halted},      32'd0);
      chk("rst_illegal", {31'd0, illegal},     32'd0);
      tick();
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: every transfer must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
         if (exp_pc_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: got pc %0h expected no transfer", instr_pc);
         end else begin
            logic [7:0]  epc;
            logic [15:0] ew;
            epc = exp_pc_q.pop_front();
            ew  = exp_w_q.pop_front();
            chk("sb_pc",     {24'd0, instr_pc}, {24'd0, epc});
            chk("sb_instr",  {16'd0, instr},    {16'd0, ew});
            chk("sb_opcode", {28'd0, opcode},   {28'd0, ew[15:12]});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      total = 0;
      bad = 0;
      for (int k = 0; k < 256; k++) mem[k] = {4'h0, 12'(k)};
      redirect_pc = 8'h00;

      // ---- stream, backpressure 5-9 and 14-16, redirect 0x40 in 16 ----
      do_reset();
      for (int k = 0; k <= 6; k++) push_exp(8'(k));
      for (int k = 0; k <= 3; k++) push_exp(8'(8'h40 + k));
      for (int c = 0; c <= 23; c++) begin
         instr_ready    = !(c >= 5 && c <= 9) && !(c >= 14 && c <= 16) && (c < 23);
         redirect_valid = (c == 16);
         redirect_pc    = 8'h40;
         @(negedge clk);
         if (c == 0)  begin chk("c0_en", {31'd0, imem_en}, 32'd1); chk("c0_addr", {24'd0, imem_addr}, 32'd0); end
         if (c == 1)  chk("c1_valid", {31'd0, instr_valid}, 32'd0);
         if (c == 2)  begin chk("c2_valid", {31'd0, instr_valid}, 32'd1); chk("c2_pc", {24'd0, instr_pc}, 32'd0); end
         if (c == 5)  chk("bp_en_full", {31'd0, imem_en}, 32'd0);
         if (c == 7)  begin chk("bp_pc", {24'd0, instr_pc}, 32'd3); chk("bp_valid", {31'd0, instr_valid}, 32'd1);
                            chk("bp_en", {31'd0, imem_en}, 32'd0); end
         if (c == 9)  chk("bp_pc_hold", {24'd0, instr_pc}, 32'd3);
         if (c == 16) chk("rd_en_n", {31'd0, imem_en}, 32'd0);
         if (c == 17) begin chk("rd_valid_n1", {31'd0, instr_valid}, 32'd0); chk("rd_en_n1", {31'd0, imem_en}, 32'd1);
                            chk("rd_addr_n1", {24'd0, imem_addr}, 32'h40); end
         if (c == 18) chk("rd_valid_n2", {31'd0, instr_valid}, 32'd0);
         if (c == 19) begin chk("rd_valid_n3", {31'd0, instr_valid}, 32'd1); chk("rd_pc_n3", {24'd0, instr_pc}, 32'h40); end
         tick();
      end
      chk("t1_drained", exp_pc_q.size(), 32'd0);

      // ---- illegal opcode at PC 5 halts; later redirect ignored ----
      mem[5] = 16'h8123;
      do_reset();
      for (int k = 0; k <= 4; k++) push_exp(8'(k));
      for (int c = 0; c <= 12; c++) begin
         instr_ready    = 1'b1;
         redirect_valid = (c == 9);
         redirect_pc    = 8'h10;
         @(negedge clk);
         if (c == 6)  begin chk("ill_pre_halt", {31'd0, halted}, 32'd0); chk("ill_pc4", {24'd0, instr_pc}, 32'd4); end
         if (c == 7)  begin chk("ill_halted", {31'd0, halted}, 32'd1); chk("ill_flag", {31'd0, illegal}, 32'd1);
                            chk("ill_en", {31'd0, imem_en}, 32'd0); chk("ill_valid", {31'd0, instr_valid}, 32'd0); end
         if (c == 10) begin chk("ill_rd_valid", {31'd0, instr_valid}, 32'd0); chk("ill_rd_en", {31'd0, imem_en}, 32'd0);
                            chk("ill_rd_halted", {31'd0, halted}, 32'd1); end
         if (c == 12) chk("ill_late_valid", {31'd0, instr_valid}, 32'd0);
         tick();
      end
      chk("t2_drained", exp_pc_q.size(), 32'd0);

      // ---- redirect wins over illegal load in the same cycle ----
      do_reset();
      for (int k = 0; k <= 4; k++) push_exp(8'(k));
      push_exp(8'h20);
      push_exp(8'h21);
      for (int c = 0; c <= 11; c++) begin
         instr_ready    = (c < 11);
         redirect_valid = (c == 6);
         redirect_pc    = 8'h20;
         @(negedge clk);
         if (c == 7)  begin chk("pri_halted", {31'd0, halted}, 32'd0); chk("pri_valid_n1", {31'd0, instr_valid}, 32'd0);
                            chk("pri_addr", {24'd0, imem_addr}, 32'h20); chk("pri_en", {31'd0, imem_en}, 32'd1); end
         if (c == 8)  chk("pri_valid_n2", {31'd0, instr_valid}, 32'd0);
         if (c == 9)  begin chk("pri_valid_n3", {31'd0, instr_valid}, 32'd1); chk("pri_pc_n3", {24'd0, instr_pc}, 32'h20); end
         if (c == 11) begin chk("pri_illegal", {31'd0, illegal}, 32'd0); chk("pri_halted_end", {31'd0, halted}, 32'd0); end
         tick();
      end
      chk("t3_drained", exp_pc_q.size(), 32'd0);
      mem[5] = 16'h0005;

      // ---- PC wrap 0xFE..0x01, then one-cycle reset mid-stream ----
      do_reset();
      push_exp(8'h00); push_exp(8'h01);
      push_exp(8'hFE); push_exp(8'hFF); push_exp(8'h00); push_exp(8'h01); push_exp(8'h02);
      for (int c = 0; c <= 10; c++) begin
         instr_ready    = 1'b1;
         redirect_valid = (c == 3);
         redirect_pc    = 8'hFE;
         @(negedge clk);
         if (c == 4) chk("wr_addr", {24'd0, imem_addr}, 32'hFE);
         if (c == 6) chk("wr_pc_fe", {24'd0, instr_pc}, 32'hFE);
         if (c == 8) begin chk("wr_pc_00", {24'd0, instr_pc}, 32'h00); chk("wr_valid", {31'd0, instr_valid}, 32'd1); end
         if (c == 9) chk("wr_pc_01", {24'd0, instr_pc}, 32'h01);
         tick();
      end
      chk("t4_drained", exp_pc_q.size(), 32'd0);

      rst_n = 1'b0;
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      push_exp(8'h00); push_exp(8'h01); push_exp(8'h02);
      for (int c = 0; c <= 5; c++) begin
         instr_ready = (c < 5);
         @(negedge clk);
         if (c == 0) begin chk("mr_valid", {31'd0, instr_valid}, 32'd0); chk("mr_instr", {16'd0, instr}, 32'd0);
                           chk("mr_pc", {24'd0, instr_pc}, 32'd0); chk("mr_opcode", {28'd0, opcode}, 32'd0);
                           chk("mr_halted", {31'd0, halted}, 32'd0); chk("mr_addr", {24'd0, imem_addr}, 32'd0);
                           chk("mr_en", {31'd0, imem_en}, 32'd1); end
         if (c == 1) chk("mr_valid_c1", {31'd0, instr_valid}, 32'd0);
         if (c == 2) begin chk("mr_valid_c2", {31'd0, instr_valid}, 32'd1); chk("mr_pc_c2", {24'd0, instr_pc}, 32'd0); end
         tick();
      end
      chk("t5_drained", exp_pc_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_issue.md
Name: instr_issue

Overview:
- Instruction fetch/issue unit. Produces the instruction stream whose opcode field feeds the control decoder.
- Holds the PC and reads a synchronous instruction memory with 1-cycle read latency.
- Buffers responses in a 2-entry queue and presents them downstream over a valid/ready handshake.
- Accepts branch/jump redirects from execute; halts permanently on any opcode the decoder does not define (8..15).

Parameters:
PC_W  8  width of PC and instruction-memory address
INSTR_W  16  instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
imem_en  output  1  read strobe; a read is issued in every cycle this is 1
imem_addr  output  PC_W  read address, valid when imem_en=1
imem_rdata  input  INSTR_W  read data, valid in the cycle after the read was issued
instr_valid  output  1  instr/opcode/instr_pc hold a valid instruction
instr_ready  input  1  downstream accepts; transfer ("fire") = instr_valid & instr_ready
instr  output  INSTR_W  issued instruction word
opcode  output  4  instr[INSTR_W-1:INSTR_W-4], to the control decoder
instr_pc  output  PC_W  address of the issued instruction
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  PC_W  redirect target
halted  output  1  fetch stopped
illegal  output  1  halt was caused by an undefined opcode

Behaviour:
- Reset (rst_n=0 at a rising edge): every output is 0; fetch_pc=0; both queue entries invalid; any in-flight read is discarded; state=RUN.
  - Applies mid-operation identically, including while halted.
- Storage: head register (drives outputs), skid register, pending flag (a read was issued last cycle).
- Registered outputs: instr/opcode/instr_pc change only when the head loads.
  - While instr_valid=1 and instr_ready=0, outputs are stable.
- Read issue, state RUN: imem_en=1 when occ<=1 and redirect_valid=0.
  - occ = (instr_valid & ~fire) + skid_valid + pending.
  - imem_addr=fetch_pc. fetch_pc increments mod 2^PC_W (255 -> 0 wraps silently).
- Response capture: when pending=1, imem_rdata is written with its PC to the head if the head is empty or firing and skid is empty; otherwise it goes to skid.
  - On fire with skid valid, skid moves to head.
  - Order is preserved. No response is ever dropped except by flush.
- Throughput: 1 instr/cycle with instr_ready held high.
- Startup latency: first cycle with rst_n=1 is cycle 0.
  - Read of PC 0 is issued in cycle 0.
  - instr_valid=1 with instr_pc=0 in cycle 2.
- Redirect in cycle N (state RUN):
  - Flushes head, skid, and the pending response; no read is issued in cycle N.
  - fetch_pc=redirect_pc after the edge.
  - instr_valid=0 in N+1 and N+2.
  - Read of redirect_pc is issued in N+1; instr_valid=1 with instr_pc=redirect_pc in N+3.
  - A fire in cycle N still counts as a transfer.
- Illegal detection: an entry with opcode[3]=1 about to load into the head is not presented.
  - All entries and the pending read are discarded; state=HALT.
  - halted=1 and illegal=1 from the next cycle.
- HALT: imem_en=0, instr_valid=0, redirect_valid ignored. Exit only via reset.
- Priority: redirect_valid in the same cycle an illegal entry would load means the redirect wins; no halt.
- No stall/backpressure on the imem side; memory always answers in exactly 1 cycle.

Test Plan:
- Reset release, imem[k]={4'h0,k[11:0]}, instr_ready=1 -> instr_valid rises in cycle 2; instr_pc=0,1,2,... every cycle; opcode=0.
- Backpressure: instr_ready=0 for cycles 5-9 -> instr/instr_pc frozen, imem_en=0 once occ=2, nothing lost or duplicated; sequence resumes contiguously when instr_ready=1.
- Redirect to 0x40 in cycle 10 with both entries full -> instr_valid=0 in 11-12; cycle 13 instr_pc=0x40; flushed PCs never issued.
- imem[5]=16'h8123 -> instr_pcs 0-4 issue, PC 5 never presented, halted=illegal=1, imem_en=0; a later redirect is ignored.
- redirect_valid in the same cycle the illegal word at PC 5 would load -> no halt; the redirect target issues in N+3.
- Wrap: redirect to 0xFE -> instr_pc 0xFE, 0xFF, 0x00, 0x01. Then rst_n=0 for 1 cycle mid-stream -> all outputs 0 and the sequence restarts at PC 0 in cycle 2.
